// File: rtl/voice_allocator_pkg.sv
// voice_allocator_pkg: shared widths and FSM state encoding for the voice allocator
package voice_allocator_pkg;

  localparam int DEF_NOTE_W = 7;
  localparam int DEF_VEL_W  = 7;
  localparam int DEF_AGE_W  = 8;

  typedef logic [1:0] alloc_state_t;

  localparam alloc_state_t S_IDLE   = 2'd0;
  localparam alloc_state_t S_SCAN   = 2'd1;
  localparam alloc_state_t S_COMMIT = 2'd2;

endpackage

// File: rtl/voice_allocator_scan.sv
// voice_scan_unit: folds one voice per cycle into match / free / oldest candidate registers
module voice_scan_unit
  import voice_allocator_pkg::*;
#(
  parameter int IDX_W  = 2,
  parameter int NOTE_W = DEF_NOTE_W,
  parameter int AGE_W  = DEF_AGE_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              step,
  input  logic [IDX_W-1:0]  idx,
  input  logic              gate,
  input  logic [NOTE_W-1:0] note,
  input  logic [AGE_W-1:0]  age,
  input  logic [NOTE_W-1:0] evt_note,
  output logic              match_found,
  output logic [IDX_W-1:0]  match_idx,
  output logic              free_found,
  output logic [IDX_W-1:0]  free_idx,
  output logic [IDX_W-1:0]  old_idx
);

  logic             old_found;
  logic [AGE_W-1:0] old_age;

  // First hit wins for match and free; oldest uses strict > so ties keep the lowest index
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n || clear) begin
      match_found <= 1'b0;
      match_idx   <= '0;
      free_found  <= 1'b0;
      free_idx    <= '0;
      old_found   <= 1'b0;
      old_idx     <= '0;
      old_age     <= '0;
    end else if (step) begin
      if (gate && note == evt_note && !match_found) begin
        match_found <= 1'b1;
        match_idx   <= idx;
      end
      if (!gate && !free_found) begin
        free_found <= 1'b1;
        free_idx   <= idx;
      end
      if (gate && (!old_found || age > old_age)) begin
        old_found <= 1'b1;
        old_idx   <= idx;
        old_age   <= age;
      end
    end

endmodule

// File: rtl/voice_allocator.sv
// voice_allocator: polyphonic note-to-voice scheduler with oldest-voice stealing
module voice_allocator
  import voice_allocator_pkg::*;
#(
  parameter int NUM_VOICES = 4,
  parameter int NOTE_W     = DEF_NOTE_W,
  parameter int VEL_W      = DEF_VEL_W,
  parameter int AGE_W      = DEF_AGE_W
) (
  input  logic                         CLK_50MHZ,
  input  logic                         RST_N,
  input  logic                         evt_valid,
  output logic                         evt_ready,
  input  logic                         evt_on,
  input  logic [NOTE_W-1:0]            evt_note,
  input  logic [VEL_W-1:0]             evt_vel,
  output logic [NUM_VOICES*NOTE_W-1:0] voice_note,
  output logic [NUM_VOICES*VEL_W-1:0]  voice_vel,
  output logic [NUM_VOICES-1:0]        voice_gate,
  output logic [NUM_VOICES-1:0]        voice_trig,
  output logic                         steal_pulse
);

  localparam int IDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_VOICES - 1);

  alloc_state_t                         state, next_state;
  logic [IDX_W-1:0]                     scan_idx;
  logic                                 ready_q;
  logic                                 ev_on;
  logic [NOTE_W-1:0]                    ev_note;
  logic [VEL_W-1:0]                     ev_vel;
  logic [NUM_VOICES-1:0][NOTE_W-1:0]    note_q;
  logic [NUM_VOICES-1:0][VEL_W-1:0]     vel_q;
  logic [NUM_VOICES-1:0][AGE_W-1:0]     age_q;
  logic [NUM_VOICES-1:0]                gate_q;
  logic [NUM_VOICES-1:0]                trig_q;
  logic                                 steal_q;
  logic                                 match_found, free_found;
  logic [IDX_W-1:0]                     match_idx, free_idx, old_idx, sel;
  logic                                 accept;

  assign accept      = evt_valid & ready_q;
  assign evt_ready   = ready_q;
  assign voice_note  = note_q;
  assign voice_vel   = vel_q;
  assign voice_gate  = gate_q;
  assign voice_trig  = trig_q;
  assign steal_pulse = steal_q;
  assign sel         = match_found ? match_idx : free_found ? free_idx : old_idx;

  // IDLE -> SCAN (one voice per cycle) -> COMMIT -> IDLE
  always_comb
    next_state = (state == S_IDLE) ? (accept ? S_SCAN : S_IDLE) :
                 (state == S_SCAN) ? ((scan_idx == LAST) ? S_COMMIT : S_SCAN) : S_IDLE;

  // State, scan pointer and registered ready (low through reset, high once back in IDLE)
  always_ff @(posedge CLK_50MHZ or negedge RST_N)
    if (!RST_N) begin
      state    <= S_IDLE;
      scan_idx <= '0;
      ready_q  <= 1'b0;
    end else begin
      state    <= next_state;
      scan_idx <= (state == S_SCAN && scan_idx != LAST) ? scan_idx + 1'b1 : '0;
      ready_q  <= next_state == S_IDLE;
    end

  // Capture the event at acceptance; a zero-velocity note-on is folded into a note-off here
  always_ff @(posedge CLK_50MHZ or negedge RST_N)
    if (!RST_N) begin
      ev_on   <= 1'b0;
      ev_note <= '0;
      ev_vel  <= '0;
    end else if (accept) begin
      ev_on   <= evt_on && evt_vel != '0;
      ev_note <= evt_note;
      ev_vel  <= evt_vel;
    end

  voice_scan_unit #(
    .IDX_W  (IDX_W),
    .NOTE_W (NOTE_W),
    .AGE_W  (AGE_W)
  ) u_scan (
    .clk         (CLK_50MHZ),
    .rst_n       (RST_N),
    .clear       (accept),
    .step        (state == S_SCAN),
    .idx         (scan_idx),
    .gate        (gate_q[scan_idx]),
    .note        (note_q[scan_idx]),
    .age         (age_q[scan_idx]),
    .evt_note    (ev_note),
    .match_found (match_found),
    .match_idx   (match_idx),
    .free_found  (free_found),
    .free_idx    (free_idx),
    .old_idx     (old_idx)
  );

  // Voice table update on the COMMIT edge; trig/steal are single-cycle pulses after it
  always_ff @(posedge CLK_50MHZ or negedge RST_N)
    if (!RST_N) begin
      note_q  <= '0;
      vel_q   <= '0;
      age_q   <= '0;
      gate_q  <= '0;
      trig_q  <= '0;
      steal_q <= 1'b0;
    end else begin
      trig_q  <= '0;
      steal_q <= 1'b0;
      if (state == S_COMMIT) begin
        steal_q <= ev_on && !match_found && !free_found;
        for (int i = 0; i < NUM_VOICES; i++)
          if (ev_on) begin
            if (sel == IDX_W'(i)) begin
              note_q[i] <= ev_note;
              vel_q[i]  <= ev_vel;
              gate_q[i] <= 1'b1;
              age_q[i]  <= '0;
              trig_q[i] <= 1'b1;
            end else if (gate_q[i])
              age_q[i] <= (&age_q[i]) ? age_q[i] : age_q[i] + 1'b1;
          end else if (gate_q[i] && note_q[i] == ev_note)
            gate_q[i] <= 1'b0;
      end
    end

endmodule

// File: tb/tb_voice_allocator.sv
// tb_voice_allocator: directed + random stimulus against a behavioural voice-table model
module tb_voice_allocator;

  localparam int N = 4;

  logic          CLK_50MHZ = 1'b0;
  logic          RST_N = 1'b0;
  logic          evt_valid = 1'b0;
  logic          evt_ready;
  logic          evt_on = 1'b0;
  logic [6:0]    evt_note = '0;
  logic [6:0]    evt_vel = '0;
  logic [N*7-1:0] voice_note;
  logic [N*7-1:0] voice_vel;
  logic [N-1:0]  voice_gate;
  logic [N-1:0]  voice_trig;
  logic          steal_pulse;

  int total = 0;
  int bad = 0;

  int m_note[N];
  int m_vel[N];
  int m_age[N];
  bit m_gate[N];
  logic [N-1:0] exp_trig;
  logic         exp_steal;

  voice_allocator #(.NUM_VOICES(N)) dut (
    .CLK_50MHZ   (CLK_50MHZ),
    .RST_N       (RST_N),
    .evt_valid   (evt_valid),
    .evt_ready   (evt_ready),
    .evt_on      (evt_on),
    .evt_note    (evt_note),
    .evt_vel     (evt_vel),
    .voice_note  (voice_note),
    .voice_vel   (voice_vel),
    .voice_gate  (voice_gate),
    .voice_trig  (voice_trig),
    .steal_pulse (steal_pulse)
  );

  always #5 CLK_50MHZ = ~CLK_50MHZ;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_note[i] = 0; m_vel[i] = 0; m_age[i] = 0; m_gate[i] = 0;
    end
  endtask

  // Reference behaviour: retrigger match, else lowest free, else steal oldest (lowest on tie)
  task automatic model_apply(input bit on, input int note, input int vel);
    int s;
    exp_trig = '0;
    exp_steal = 1'b0;
    if (on && vel != 0) begin
      s = -1;
      for (int i = 0; i < N; i++) if (s < 0 && m_gate[i] && m_note[i] == note) s = i;
      for (int i = 0; i < N; i++) if (s < 0 && !m_gate[i]) s = i;
      if (s < 0) begin
        exp_steal = 1'b1;
        for (int i = 0; i < N; i++) if (s < 0 || m_age[i] > m_age[s]) s = i;
      end
      for (int i = 0; i < N; i++)
        if (i == s) begin
          m_note[i] = note; m_vel[i] = vel; m_gate[i] = 1; m_age[i] = 0;
        end else if (m_gate[i])
          m_age[i] = (m_age[i] + 1 > 255) ? 255 : m_age[i] + 1;
      exp_trig[s] = 1'b1;
    end else
      for (int i = 0; i < N; i++) if (m_gate[i] && m_note[i] == note) m_gate[i] = 0;
  endtask

  task automatic check_state(input string tag, input logic [N-1:0] trig_e, input logic steal_e);
    logic [N*7-1:0] en, ev;
    logic [N-1:0]   eg;
    for (int i = 0; i < N; i++) begin
      en[i*7 +: 7] = 7'(m_note[i]);
      ev[i*7 +: 7] = 7'(m_vel[i]);
      eg[i] = m_gate[i];
    end
    chk({tag, ".note"}, 64'(voice_note), 64'(en));
    chk({tag, ".vel"}, 64'(voice_vel), 64'(ev));
    chk({tag, ".gate"}, 64'(voice_gate), 64'(eg));
    chk({tag, ".trig"}, 64'(voice_trig), 64'(trig_e));
    chk({tag, ".steal"}, 64'(steal_pulse), 64'(steal_e));
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!evt_ready && n < 50) begin
      @(posedge CLK_50MHZ); #1;
      n++;
    end
    chk("ready_wait", 64'(evt_ready), 64'd1);
  endtask

  // One event end to end: outputs frozen for N cycles, updated on the (N+1)th edge, pulses gone after
  task automatic send(input bit on, input int note, input int vel);
    wait_ready();
    evt_valid = 1'b1; evt_on = on; evt_note = 7'(note); evt_vel = 7'(vel);
    @(posedge CLK_50MHZ); #1;
    evt_valid = 1'b0; evt_on = 1'($urandom); evt_note = 7'($urandom); evt_vel = 7'($urandom);
    chk("busy", 64'(evt_ready), 64'd0);
    repeat (N) @(posedge CLK_50MHZ);
    #1 check_state("pre", '0, 1'b0);
    model_apply(on, note, vel);
    @(posedge CLK_50MHZ); #1;
    check_state("commit", exp_trig, exp_steal);
    chk("ready_back", 64'(evt_ready), 64'd1);
    @(posedge CLK_50MHZ); #1;
    check_state("post", '0, 1'b0);
  endtask

  task automatic do_reset();
    RST_N = 1'b0;
    #1;
    model_reset();
    check_state("rst", '0, 1'b0);
    chk("rst.ready", 64'(evt_ready), 64'd0);
    repeat (2) @(posedge CLK_50MHZ);
    #3 RST_N = 1'b1;
    @(posedge CLK_50MHZ); #1;
    chk("rst.ready_rise", 64'(evt_ready), 64'd1);
  endtask

  initial begin
    bit          ev_on[3];
    int          ev_note[3];
    int          ev_vel[3];
    int          accepted, last, cyc;
    logic        rdy;
    #2;
    do_reset();

    // Single note-on lands in voice 0
    send(1, 60, 100);

    // Fill all voices then steal the oldest (voice 0)
    send(1, 62, 90); send(1, 64, 80); send(1, 67, 70); send(1, 72, 60);
    chk("steal.v0note", 64'(voice_note[6:0]), 64'd72);

    // Note-off 62 frees voice 1, reused next; vel-0 note-on frees voice 2
    send(0, 62, 50);
    send(1, 70, 40);
    send(1, 64, 0);
    send(1, 71, 33);

    // Retrigger an already-sounding note
    do_reset();
    send(1, 50, 10); send(1, 52, 11); send(1, 60, 12);
    send(1, 60, 99);
    send(0, 99, 5);

    // Events with evt_valid held high continuously
    ev_on = '{1, 1, 0}; ev_note = '{30, 31, 30}; ev_vel = '{20, 21, 22};
    wait_ready();
    evt_valid = 1'b1; evt_on = ev_on[0]; evt_note = 7'(ev_note[0]); evt_vel = 7'(ev_vel[0]);
    accepted = 0; last = 0; cyc = 0;
    while (accepted < 3 && cyc < 60) begin
      rdy = evt_ready;
      @(posedge CLK_50MHZ); #1;
      cyc++;
      if (rdy) begin
        if (accepted > 0) chk("stream.interval", 64'(cyc - last), 64'(N + 2));
        last = cyc;
        model_apply(ev_on[accepted], ev_note[accepted], ev_vel[accepted]);
        accepted++;
        if (accepted < 3) begin
          evt_on = ev_on[accepted]; evt_note = 7'(ev_note[accepted]); evt_vel = 7'(ev_vel[accepted]);
        end else evt_valid = 1'b0;
      end
    end
    chk("stream.count", 64'(accepted), 64'd3);
    repeat (N + 2) @(posedge CLK_50MHZ);
    #1 check_state("stream.end", '0, 1'b0);

    // Random traffic over a small note range to force matches and steals
    for (int k = 0; k < 40; k++)
      send($urandom_range(0, 3) != 0, 60 + $urandom_range(0, 5),
           ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 127));

    // Reset in the middle of SCAN: immediate clear, no late commit
    wait_ready();
    evt_valid = 1'b1; evt_on = 1'b1; evt_note = 7'd88; evt_vel = 7'd77;
    @(posedge CLK_50MHZ); #1;
    evt_valid = 1'b0;
    @(posedge CLK_50MHZ); #1;
    RST_N = 1'b0;
    #1;
    model_reset();
    check_state("midrst", '0, 1'b0);
    chk("midrst.ready", 64'(evt_ready), 64'd0);
    #2 RST_N = 1'b1;
    @(posedge CLK_50MHZ); #1;
    chk("midrst.ready_rise", 64'(evt_ready), 64'd1);
    repeat (N + 2) @(posedge CLK_50MHZ);
    #1 check_state("midrst.nocommit", '0, 1'b0);

    // Age saturation: a long-held voice must still be the oldest after 350 allocations
    send(1, 10, 1);
    for (int k = 0; k < 250; k++) begin send(1, 20, 2); send(0, 20, 2); end
    send(1, 30, 3);
    for (int k = 0; k < 100; k++) begin send(1, 40, 4); send(0, 40, 4); end
    send(1, 41, 5); send(1, 42, 6); send(1, 43, 7);
    chk("sat.v0note", 64'(voice_note[6:0]), 64'd43);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
